// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//
// Purpose:
//   Bundles the signals exchanged between the multi-cycle RV32I controller and
//   its shared-memory datapath. The controller side uses the master modport.
//   The datapath (or a testbench standing in for it) uses the slave modport.
//
// Signal summary:
//   op        [6:0]   opcode field of the instruction register  (dp -> ctrl)
//   Zero              ALU zero flag                              (dp -> ctrl)
//   MemReady          memory completes the current access        (dp -> ctrl)
//   PCWrite           PC register enable                         (ctrl -> dp)
//   AdrSrc            memory address select 0=PC 1=ALUOut        (ctrl -> dp)
//   MemWrite          memory write strobe                        (ctrl -> dp)
//   IRWrite           instruction register / OldPC enable        (ctrl -> dp)
//   ResultSrc [1:0]   00=ALUOut 01=Data 10=ALUResult             (ctrl -> dp)
//   ALUSrcA   [1:0]   00=PC 01=OldPC 10=rs1 data                 (ctrl -> dp)
//   ALUSrcB   [1:0]   00=rs2 data 01=immediate 10=constant 4     (ctrl -> dp)
//   ALUOp     [1:0]   00=add 01=sub 10=funct-decoded             (ctrl -> dp)
//   RegWrite          register file write enable                 (ctrl -> dp)
//   Illegal           sticky illegal-opcode flag                 (ctrl -> dp)
//   InstRet   [CNT_W-1:0] retired-instruction count              (ctrl -> dp)
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             RegWrite;
  logic             Illegal;
  logic [CNT_W-1:0] InstRet;

  // Controller view
  modport master (
    input  op,
    input  Zero,
    input  MemReady,
    output PCWrite,
    output AdrSrc,
    output MemWrite,
    output IRWrite,
    output ResultSrc,
    output ALUSrcA,
    output ALUSrcB,
    output ALUOp,
    output RegWrite,
    output Illegal,
    output InstRet
  );

  // Datapath view
  modport slave (
    output op,
    output Zero,
    output MemReady,
    input  PCWrite,
    input  AdrSrc,
    input  MemWrite,
    input  IRWrite,
    input  ResultSrc,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ALUOp,
    input  RegWrite,
    input  Illegal,
    input  InstRet
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Moore controller for a shared-memory, multi-cycle RV32I datapath. It walks
//   each instruction through FETCH / DECODE / execute / writeback states,
//   issues the datapath enables and mux selects for each state, drives ALUOp
//   into the ALU decoder, stalls on the memory-ready handshake, traps on
//   unsupported opcodes and counts retired instructions.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   multicycle_control_if.master (opcode/flags in, controls out,
//         sticky Illegal flag and InstRet counter out)
//
// Parameters:
//   CNT_W width of the retired-instruction counter InstRet
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_if.master   bus
);

  // Supported opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // True when the opcode belongs to the supported RV32I subset
  function automatic logic op_is_legal(input logic [6:0] opc);
    logic legal;
    case (opc)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: legal = 1'b1;
      default:                                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  state_t           dec_state_s;
  logic             illegal_r;
  logic [CNT_W-1:0] instret_r;
  logic             retire_s;
  logic             set_illegal_s;

  logic             pcwrite_s;
  logic             adrsrc_s;
  logic             memwrite_s;
  logic             irwrite_s;
  logic [1:0]       resultsrc_s;
  logic [1:0]       alusrca_s;
  logic [1:0]       alusrcb_s;
  logic [1:0]       aluop_s;
  logic             regwrite_s;

  // State register; reset from any state (stall or TRAP included) lands in FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (bus.MemReady) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_RTYPE:          state_next_s = S_EXECR;
          OP_ITYPE:          state_next_s = S_EXECI;
          OP_BRANCH:         state_next_s = S_BEQ;
          OP_JAL:            state_next_s = S_JAL;
          default:           state_next_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LOAD) begin
          state_next_s = S_MEMREAD;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (bus.MemReady) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWB:  state_next_s = S_FETCH;
      S_MEMWRITE: begin
        if (bus.MemReady) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_EXECR:  state_next_s = S_ALUWB;
      S_EXECI:  state_next_s = S_ALUWB;
      // JAL has already written the PC; ALUWB stores the link value PC+4
      S_JAL:    state_next_s = S_ALUWB;
      S_ALUWB:  state_next_s = S_FETCH;
      S_BEQ:    state_next_s = S_FETCH;
      S_TRAP:   state_next_s = S_TRAP;
      // Unreachable encodings recover through FETCH
      default:  state_next_s = S_FETCH;
    endcase
  end

  // Output decode state: while rst is high the outputs show FETCH values, so no
  // write strobe from an interrupted MEMWRITE/MEMWB leaks into the reset cycle
  always_comb begin
    if (rst) begin
      dec_state_s = S_FETCH;
    end else begin
      dec_state_s = state_r;
    end
  end

  // Moore output decode (MemReady gates the fetch enables, Zero gates BEQ)
  always_comb begin
    pcwrite_s   = 1'b0;
    adrsrc_s    = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    resultsrc_s = 2'b00;
    alusrca_s   = 2'b00;
    alusrcb_s   = 2'b00;
    aluop_s     = 2'b00;
    regwrite_s  = 1'b0;
    case (dec_state_s)
      S_FETCH: begin
        // PC <= PC + 4 via ALUResult and IR load both wait for the memory
        adrsrc_s    = 1'b0;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b10;
        aluop_s     = 2'b00;
        resultsrc_s = 2'b10;
        irwrite_s   = bus.MemReady;
        pcwrite_s   = bus.MemReady;
      end
      S_DECODE: begin
        // Precompute OldPC + imm as a branch/jump target
        alusrca_s = 2'b01;
        alusrcb_s = 2'b01;
        aluop_s   = 2'b00;
      end
      S_MEMADR: begin
        alusrca_s = 2'b10;
        alusrcb_s = 2'b01;
        aluop_s   = 2'b00;
      end
      S_MEMREAD: begin
        adrsrc_s    = 1'b1;
        resultsrc_s = 2'b00;
      end
      S_MEMWB: begin
        resultsrc_s = 2'b01;
        regwrite_s  = 1'b1;
      end
      S_MEMWRITE: begin
        // Strobe held through stall cycles until the memory accepts it
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECR: begin
        alusrca_s = 2'b10;
        alusrcb_s = 2'b00;
        aluop_s   = 2'b10;
      end
      S_EXECI: begin
        alusrca_s = 2'b10;
        alusrcb_s = 2'b01;
        aluop_s   = 2'b10;
      end
      S_ALUWB: begin
        resultsrc_s = 2'b00;
        regwrite_s  = 1'b1;
      end
      S_BEQ: begin
        // ALUOut holds the target from DECODE; the subtract sets Zero
        alusrca_s   = 2'b10;
        alusrcb_s   = 2'b00;
        aluop_s     = 2'b01;
        resultsrc_s = 2'b00;
        pcwrite_s   = bus.Zero;
      end
      S_JAL: begin
        // PC <= target (ALUOut) while ALU forms OldPC + 4 for the link
        alusrca_s   = 2'b01;
        alusrcb_s   = 2'b10;
        aluop_s     = 2'b00;
        resultsrc_s = 2'b00;
        pcwrite_s   = 1'b1;
      end
      S_TRAP: begin
        pcwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
      end
      default: begin
        pcwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
      end
    endcase
  end

  // Retire and trap events, both qualified by the transition actually taken
  always_comb begin
    retire_s      = 1'b0;
    set_illegal_s = 1'b0;
    if (state_next_s == S_FETCH) begin
      case (state_r)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire_s = 1'b1;
        default:                             retire_s = 1'b0;
      endcase
    end else begin
      retire_s = 1'b0;
    end
    if ((state_r == S_DECODE) && !op_is_legal(bus.op)) begin
      set_illegal_s = 1'b1;
    end else begin
      set_illegal_s = 1'b0;
    end
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (set_illegal_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  assign bus.PCWrite   = pcwrite_s;
  assign bus.AdrSrc    = adrsrc_s;
  assign bus.MemWrite  = memwrite_s;
  assign bus.IRWrite   = irwrite_s;
  assign bus.ResultSrc = resultsrc_s;
  assign bus.ALUSrcA   = alusrca_s;
  assign bus.ALUSrcB   = alusrcb_s;
  assign bus.ALUOp     = aluop_s;
  assign bus.RegWrite  = regwrite_s;
  assign bus.Illegal   = illegal_r;
  assign bus.InstRet   = instret_r;

endmodule
